// File: rtl/utpu_pkg.sv
// ---------------------------------------------------------------------------
// utpu_pkg
// Shared definitions for the uTPU host command sequencer:
//   - host opcodes received over UART
//   - single-byte responses returned over UART
//   - state encoding of the host controller FSM
//   - small opcode helper
// ---------------------------------------------------------------------------
package utpu_pkg;

   // Host opcodes
   localparam logic [7:0] OP_LOAD_W = 8'h01;
   localparam logic [7:0] OP_LOAD_X = 8'h02;
   localparam logic [7:0] OP_RUN    = 8'h03;
   localparam logic [7:0] OP_READ   = 8'h04;

   // Single-byte responses
   localparam logic [7:0] RSP_ACK  = 8'hA5;
   localparam logic [7:0] RSP_DONE = 8'hD0;
   localparam logic [7:0] RSP_ERR  = 8'hEE;

   typedef enum logic [2:0] {
      ST_IDLE      = 3'd0,
      ST_LOAD      = 3'd1,
      ST_RUN_START = 3'd2,
      ST_RUN_WAIT  = 3'd3,
      ST_RD_ADDR   = 3'd4,
      ST_RD_WAIT   = 3'd5,
      ST_RD_SEND   = 3'd6,
      ST_SEND      = 3'd7
   } ctrl_state_e;

   // Buffer select for a load opcode: activation buffer only for LOAD_X.
   function automatic logic op_is_act(input logic [7:0] op);
      return (op == OP_LOAD_X);
   endfunction

endpackage

// File: rtl/utpu_byte_serializer.sv
// ---------------------------------------------------------------------------
// utpu_byte_serializer
// Loads a W-bit word and offers its bytes MSB first on a valid/ready byte
// handshake. Used with W = ACC_W for result words and W = 8 for single-byte
// responses.
//
// Ports:
//   clk, rst_n     clock, asynchronous active-low reset
//   load_i         capture word_i and start emitting (only while idle)
//   word_i         word to emit
//   tx_ready_i     downstream accepts the current byte when tx_valid_o is high
//   tx_valid_o     a byte is being offered (registered)
//   tx_data_o      byte offered, stable while tx_valid_o is high
//   last_o         the final byte of the word is accepted this cycle
// ---------------------------------------------------------------------------
module utpu_byte_serializer #(
   parameter int W = 32
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         load_i,
   input  logic [W-1:0] word_i,
   input  logic         tx_ready_i,
   output logic         tx_valid_o,
   output logic [7:0]   tx_data_o,
   output logic         last_o
);

   localparam int NB    = W / 8;
   localparam int CNT_W = $clog2(NB + 1);

   logic [W-1:0]     shift_q, shift_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             valid_q, valid_d;
   logic             fire;

   assign fire   = valid_q && tx_ready_i;
   assign last_o = fire && (cnt_q == CNT_W'(1));

   always_comb begin
      shift_d = shift_q;
      cnt_d   = cnt_q;
      valid_d = valid_q;
      if (load_i) begin
         shift_d = word_i;
         cnt_d   = CNT_W'(NB);
         valid_d = 1'b1;
      end else if (fire) begin
         if (cnt_q == CNT_W'(1)) begin
            // Clear the shifter so tx_data reads 0 whenever nothing is offered.
            shift_d = '0;
            cnt_d   = '0;
            valid_d = 1'b0;
         end else begin
            shift_d = shift_q << 8;
            cnt_d   = cnt_q - CNT_W'(1);
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         shift_q <= '0;
         cnt_q   <= '0;
         valid_q <= 1'b0;
      end else begin
         shift_q <= shift_d;
         cnt_q   <= cnt_d;
         valid_q <= valid_d;
      end
   end

   assign tx_valid_o = valid_q;
   assign tx_data_o  = shift_q[W-1 -: 8];

endmodule

// File: rtl/utpu_host_ctrl.sv
// ---------------------------------------------------------------------------
// utpu_host_ctrl
// Byte-level command sequencer between the UART byte interfaces and the
// uTPU compute core. Decodes host opcodes, streams operand bytes into the
// weight/activation buffers, launches the core (by opcode or board start
// pulse) and streams result words back over TX, MSB first.
//
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   start                 one-cycle RUN request, honoured only in IDLE
//   rx_valid, rx_data     received byte strobe and byte
//   tx_valid, tx_ready,   byte offered to the transmitter; accepted when
//   tx_data                 tx_valid && tx_ready
//   buf_we, buf_sel,      operand buffer write (sel 0 = weights,
//   buf_addr, buf_wdata     1 = activations)
//   core_start            one-cycle launch pulse to the core
//   core_done             one-cycle completion pulse from the core
//   res_addr, res_rdata   result RAM read port, data valid one cycle later
//   busy                  controller is not IDLE
//   err                   one-cycle pulse on bad opcode or load timeout
// ---------------------------------------------------------------------------
module utpu_host_ctrl
   import utpu_pkg::*;
#(
   parameter int N       = 4,
   parameter int ACC_W   = 32,
   parameter int TIMEOUT = 100000,
   parameter int ADDR_W  = $clog2(N * N)
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              start,
   input  logic              rx_valid,
   input  logic [7:0]        rx_data,
   output logic              tx_valid,
   input  logic              tx_ready,
   output logic [7:0]        tx_data,
   output logic              buf_we,
   output logic              buf_sel,
   output logic [ADDR_W-1:0] buf_addr,
   output logic [7:0]        buf_wdata,
   output logic              core_start,
   input  logic              core_done,
   output logic [ADDR_W-1:0] res_addr,
   input  logic [ACC_W-1:0]  res_rdata,
   output logic              busy,
   output logic              err
);

   localparam int                GAP_W    = $clog2(TIMEOUT + 1);
   localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(N * N - 1);
   localparam logic [GAP_W-1:0]  GAP_LAST = GAP_W'(TIMEOUT - 1);

   ctrl_state_e       state_q;
   logic [ADDR_W-1:0] idx_q;        // operand index in LOAD, word index k in READ
   logic [GAP_W-1:0]  gap_q;        // idle cycles since the last operand byte
   logic              load_sel_q;   // buffer chosen by the current load opcode
   logic              buf_we_q;
   logic              buf_sel_q;
   logic [ADDR_W-1:0] buf_addr_q;
   logic [7:0]        buf_wdata_q;
   logic              core_start_q;
   logic [ADDR_W-1:0] res_addr_q;
   logic              err_q;
   logic [7:0]        rsp_q;
   logic              rsp_load_q;

   logic              word_load;
   logic              word_valid, rsp_valid;
   logic [7:0]        word_data, rsp_data;
   logic              word_last, rsp_last;

   // The result word is captured straight from res_rdata during RD_WAIT,
   // which is the cycle the RAM presents the word for res_addr.
   assign word_load = (state_q == ST_RD_WAIT);

   utpu_byte_serializer #(.W(ACC_W)) u_word_ser (
      .clk        (clk),
      .rst_n      (rst_n),
      .load_i     (word_load),
      .word_i     (res_rdata),
      .tx_ready_i (tx_ready),
      .tx_valid_o (word_valid),
      .tx_data_o  (word_data),
      .last_o     (word_last)
   );

   // Responses are queued one cycle before the serializer loads them, which
   // gives the two-cycle core_done -> tx_valid latency.
   utpu_byte_serializer #(.W(8)) u_rsp_ser (
      .clk        (clk),
      .rst_n      (rst_n),
      .load_i     (rsp_load_q),
      .word_i     (rsp_q),
      .tx_ready_i (tx_ready),
      .tx_valid_o (rsp_valid),
      .tx_data_o  (rsp_data),
      .last_o     (rsp_last)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= ST_IDLE;
         idx_q        <= '0;
         gap_q        <= '0;
         load_sel_q   <= 1'b0;
         buf_we_q     <= 1'b0;
         buf_sel_q    <= 1'b0;
         buf_addr_q   <= '0;
         buf_wdata_q  <= '0;
         core_start_q <= 1'b0;
         res_addr_q   <= '0;
         err_q        <= 1'b0;
         rsp_q        <= '0;
         rsp_load_q   <= 1'b0;
      end else begin
         buf_we_q     <= 1'b0;
         core_start_q <= 1'b0;
         err_q        <= 1'b0;
         rsp_load_q   <= 1'b0;

         case (state_q)
            ST_IDLE: begin
               idx_q <= '0;
               gap_q <= '0;
               // start has priority; a byte arriving in the same cycle is lost.
               if (start) begin
                  core_start_q <= 1'b1;
                  state_q      <= ST_RUN_START;
               end else if (rx_valid) begin
                  case (rx_data)
                     OP_LOAD_W, OP_LOAD_X: begin
                        load_sel_q <= op_is_act(rx_data);
                        state_q    <= ST_LOAD;
                     end
                     OP_RUN: begin
                        core_start_q <= 1'b1;
                        state_q      <= ST_RUN_START;
                     end
                     OP_READ: begin
                        res_addr_q <= '0;
                        state_q    <= ST_RD_ADDR;
                     end
                     default: begin
                        rsp_q      <= RSP_ERR;
                        rsp_load_q <= 1'b1;
                        err_q      <= 1'b1;
                        state_q    <= ST_SEND;
                     end
                  endcase
               end
            end

            ST_LOAD: begin
               if (rx_valid) begin
                  buf_we_q    <= 1'b1;
                  buf_sel_q   <= load_sel_q;
                  buf_addr_q  <= idx_q;
                  buf_wdata_q <= rx_data;
                  gap_q       <= '0;
                  if (idx_q == LAST_IDX) begin
                     rsp_q      <= RSP_ACK;
                     rsp_load_q <= 1'b1;
                     state_q    <= ST_SEND;
                  end else begin
                     idx_q <= idx_q + 1'b1;
                  end
               end else if (gap_q == GAP_LAST) begin
                  // Abort; operand bytes already written stay in the buffer.
                  rsp_q      <= RSP_ERR;
                  rsp_load_q <= 1'b1;
                  err_q      <= 1'b1;
                  state_q    <= ST_SEND;
               end else begin
                  gap_q <= gap_q + 1'b1;
               end
            end

            ST_RUN_START: begin
               state_q <= ST_RUN_WAIT;
            end

            ST_RUN_WAIT: begin
               if (core_done) begin
                  rsp_q      <= RSP_DONE;
                  rsp_load_q <= 1'b1;
                  state_q    <= ST_SEND;
               end
            end

            ST_RD_ADDR: begin
               state_q <= ST_RD_WAIT;
            end

            ST_RD_WAIT: begin
               state_q <= ST_RD_SEND;
            end

            ST_RD_SEND: begin
               if (word_last) begin
                  if (idx_q == LAST_IDX) begin
                     state_q <= ST_IDLE;
                  end else begin
                     idx_q      <= idx_q + 1'b1;
                     res_addr_q <= idx_q + 1'b1;
                     state_q    <= ST_RD_ADDR;
                  end
               end
            end

            ST_SEND: begin
               if (rsp_last) begin
                  state_q <= ST_IDLE;
               end
            end

            default: begin
               state_q <= ST_IDLE;
            end
         endcase
      end
   end

   // Only one serializer is ever active, so a simple priority mux suffices.
   assign tx_valid   = word_valid | rsp_valid;
   assign tx_data    = word_valid ? word_data : rsp_data;
   assign buf_we     = buf_we_q;
   assign buf_sel    = buf_sel_q;
   assign buf_addr   = buf_addr_q;
   assign buf_wdata  = buf_wdata_q;
   assign core_start = core_start_q;
   assign res_addr   = res_addr_q;
   assign err        = err_q;
   assign busy       = (state_q != ST_IDLE);

endmodule

// File: tb/tb_utpu_host_ctrl.sv
// ---------------------------------------------------------------------------
// tb_utpu_host_ctrl
// Self-checking bench for utpu_host_ctrl (N=2, ACC_W=32, TIMEOUT=50).
// A monitor collects transmitted bytes, buffer writes and pulse counts; the
// expected traffic of each host command is derived from the command rules.
// ---------------------------------------------------------------------------
module tb_utpu_host_ctrl;

   localparam int N       = 2;
   localparam int ACC_W   = 32;
   localparam int TIMEOUT = 50;
   localparam int ADDR_W  = $clog2(N * N);
   localparam int NW      = N * N;
   localparam int NB      = ACC_W / 8;
   localparam int WR_W    = 1 + ADDR_W + 8;

   logic              clk = 1'b0;
   logic              rst_n = 1'b1;
   logic              start = 1'b0;
   logic              rx_valid = 1'b0;
   logic [7:0]        rx_data = 8'h00;
   logic              tx_valid;
   logic              tx_ready = 1'b1;
   logic [7:0]        tx_data;
   logic              buf_we;
   logic              buf_sel;
   logic [ADDR_W-1:0] buf_addr;
   logic [7:0]        buf_wdata;
   logic              core_start;
   logic              core_done = 1'b0;
   logic [ADDR_W-1:0] res_addr;
   logic [ACC_W-1:0]  res_rdata = '0;
   logic              busy;
   logic              err;

   int n_tests = 0;
   int n_fail  = 0;

   logic [ACC_W-1:0] res_mem [NW];
   logic [7:0]       tx_q [$];
   logic [WR_W-1:0]  wr_q [$];
   int               cnt_start = 0;
   int               cnt_err   = 0;
   bit               rdy_rand  = 1'b0;
   bit               pend      = 1'b0;
   logic [7:0]       pend_data = 8'h00;

   utpu_host_ctrl #(
      .N       (N),
      .ACC_W   (ACC_W),
      .TIMEOUT (TIMEOUT),
      .ADDR_W  (ADDR_W)
   ) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .start      (start),
      .rx_valid   (rx_valid),
      .rx_data    (rx_data),
      .tx_valid   (tx_valid),
      .tx_ready   (tx_ready),
      .tx_data    (tx_data),
      .buf_we     (buf_we),
      .buf_sel    (buf_sel),
      .buf_addr   (buf_addr),
      .buf_wdata  (buf_wdata),
      .core_start (core_start),
      .core_done  (core_done),
      .res_addr   (res_addr),
      .res_rdata  (res_rdata),
      .busy       (busy),
      .err        (err)
   );

   always #5 clk = ~clk;

   // Result RAM: word for res_addr appears one cycle later.
   always @(posedge clk) res_rdata <= res_mem[res_addr];

   always @(posedge clk) begin
      #1;
      tx_ready = rdy_rand ? 1'($urandom_range(0, 1)) : 1'b1;
   end

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   // Monitor, sampled mid-cycle.
   always @(negedge clk) begin
      if (!rst_n) begin
         pend = 1'b0;
      end else begin
         if (pend) begin
            check_eq("tx_hold", tx_valid, 1);
            check_eq("tx_stable", tx_data, pend_data);
         end
         if (tx_valid && tx_ready) tx_q.push_back(tx_data);
         if (buf_we) wr_q.push_back({buf_sel, buf_addr, buf_wdata});
         if (core_start) cnt_start++;
         if (err) cnt_err++;
         pend      = tx_valid && !tx_ready;
         pend_data = tx_data;
      end
   end

   task automatic send_rx(input logic [7:0] b);
      @(posedge clk); #1;
      rx_valid = 1'b1;
      rx_data  = b;
      @(posedge clk); #1;
      rx_valid = 1'b0;
   endtask

   task automatic expect_tx(input string tag, input logic [7:0] exp);
      int c = 0;
      while (tx_q.size() == 0 && c < 2000) begin
         @(negedge clk);
         c++;
      end
      if (tx_q.size() == 0) check_eq({tag, "_txcount"}, tx_q.size(), 1);
      else check_eq(tag, tx_q.pop_front(), exp);
   endtask

   task automatic wait_idle(input string tag);
      int c = 0;
      while ((busy || tx_valid) && c < 3000) begin
         @(negedge clk);
         c++;
      end
      @(negedge clk);
      check_eq({tag, "_idle"}, busy, 0);
      check_eq({tag, "_extra_tx"}, tx_q.size(), 0);
   endtask

   task automatic check_zero_outputs(input string tag);
      check_eq({tag, "_tx_valid"}, tx_valid, 0);
      check_eq({tag, "_tx_data"}, tx_data, 0);
      check_eq({tag, "_buf_we"}, buf_we, 0);
      check_eq({tag, "_buf_sel"}, buf_sel, 0);
      check_eq({tag, "_buf_addr"}, buf_addr, 0);
      check_eq({tag, "_buf_wdata"}, buf_wdata, 0);
      check_eq({tag, "_core_start"}, core_start, 0);
      check_eq({tag, "_res_addr"}, res_addr, 0);
      check_eq({tag, "_busy"}, busy, 0);
      check_eq({tag, "_err"}, err, 0);
   endtask

   task automatic do_load(input bit sel, input logic [7:0] d [NW], input bit gaps);
      int e0 = cnt_err;
      wr_q.delete();
      send_rx(sel ? 8'h02 : 8'h01);
      for (int i = 0; i < NW; i++) begin
         if (gaps) repeat ($urandom_range(0, TIMEOUT / 2)) @(posedge clk);
         send_rx(d[i]);
      end
      expect_tx("load_ack", 8'hA5);
      wait_idle("load");
      check_eq("load_nwr", wr_q.size(), NW);
      for (int i = 0; i < NW && i < wr_q.size(); i++)
         check_eq("load_wr", wr_q[i], {sel, ADDR_W'(i), d[i]});
      check_eq("load_err", cnt_err, e0);
   endtask

   task automatic do_run(input bit via_start, input int delay, input bit poke, input bit collide);
      int s0 = cnt_start;
      int e0 = cnt_err;
      int c  = 0;
      if (via_start) begin
         @(posedge clk); #1;
         start = 1'b1;
         if (collide) begin
            rx_valid = 1'b1;
            rx_data  = 8'h7F;
         end
         @(posedge clk); #1;
         start    = 1'b0;
         rx_valid = 1'b0;
      end else begin
         send_rx(8'h03);
      end
      while (cnt_start == s0 && c < 20) begin
         @(negedge clk);
         c++;
      end
      check_eq("run_core_start", cnt_start, s0 + 1);
      check_eq("run_busy", busy, 1);
      if (poke) send_rx(8'h7F);
      repeat (delay) @(posedge clk);
      #1 core_done = 1'b1;
      @(posedge clk); #1;
      core_done = 1'b0;
      @(negedge clk);
      check_eq("done_lat1_valid", tx_valid, 0);
      @(negedge clk);
      check_eq("done_lat2_valid", tx_valid, 1);
      check_eq("done_lat2_data", tx_data, 8'hD0);
      expect_tx("run_rsp", 8'hD0);
      wait_idle("run");
      check_eq("run_one_pulse", cnt_start, s0 + 1);
      check_eq("run_no_err", cnt_err, e0);
   endtask

   task automatic do_read(input string tag);
      send_rx(8'h04);
      for (int k = 0; k < NW; k++)
         for (int b = NB - 1; b >= 0; b--)
            expect_tx(tag, 8'(res_mem[k] >> (8 * b)));
      wait_idle(tag);
   endtask

   task automatic do_bad(input logic [7:0] op);
      int e0 = cnt_err;
      send_rx(op);
      expect_tx("bad_rsp", 8'hEE);
      wait_idle("bad");
      check_eq("bad_err_pulse", cnt_err, e0 + 1);
   endtask

   task automatic do_timeout();
      int e0 = cnt_err;
      int n  = 0;
      wr_q.delete();
      send_rx(8'h02);
      send_rx(8'hAA);
      while (!err && n < TIMEOUT + 20) begin
         @(negedge clk);
         n++;
      end
      check_eq("to_gap_window", (n >= TIMEOUT && n <= TIMEOUT + 2), 1);
      expect_tx("to_rsp", 8'hEE);
      wait_idle("to");
      check_eq("to_err_pulse", cnt_err, e0 + 1);
      check_eq("to_nwr", wr_q.size(), 1);
      if (wr_q.size() > 0) check_eq("to_wr", wr_q[0], {1'b1, ADDR_W'(0), 8'hAA});
   endtask

   initial begin
      #900000;
      $display("FAIL watchdog: simulation exceeded time budget");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [7:0] d [NW];
      int c;

      for (int k = 0; k < NW; k++) res_mem[k] = '0;

      // Reset
      #2 rst_n = 1'b0;
      #1 check_zero_outputs("reset");
      repeat (3) @(posedge clk);
      @(negedge clk) rst_n = 1'b1;

      // Directed LOAD_W
      d = '{8'h11, 8'h22, 8'h33, 8'h44};
      do_load(1'b0, d, 1'b0);

      // Directed RUN with a stray rx byte while waiting for the core
      do_run(1'b0, 20, 1'b1, 1'b0);

      // Directed READ, ready always high then randomly toggling
      res_mem = '{32'h01020304, 32'h05060708, 32'h0A0B0C0D, 32'hFFFFFFFF};
      do_read("read_fixed");
      rdy_rand = 1'b1;
      do_read("read_rand_rdy");
      rdy_rand = 1'b0;

      // Bad opcode and load timeout
      do_bad(8'h7F);
      do_timeout();

      // start beats a simultaneous rx byte
      do_run(1'b1, 3, 1'b0, 1'b1);

      // Randomized command mix
      for (int it = 0; it < 25; it++) begin
         rdy_rand = 1'($urandom_range(0, 1));
         case ($urandom_range(0, 5))
            0, 1: begin
               for (int i = 0; i < NW; i++) d[i] = 8'($urandom);
               do_load(1'($urandom_range(0, 1)), d, 1'b1);
            end
            2: do_run(1'b0, $urandom_range(0, 30), 1'($urandom_range(0, 1)), 1'b0);
            3: do_run(1'b1, $urandom_range(0, 30), 1'b0, 1'($urandom_range(0, 1)));
            4: begin
               for (int k = 0; k < NW; k++) res_mem[k] = $urandom;
               do_read("read_rand");
            end
            default: do_bad(8'($urandom_range(5, 256)));
         endcase
      end

      // Reset in the middle of a READ
      rdy_rand = 1'b0;
      for (int k = 0; k < NW; k++) res_mem[k] = $urandom;
      send_rx(8'h04);
      c = 0;
      while (tx_q.size() < 5 && c < 500) begin
         @(negedge clk);
         c++;
      end
      check_eq("rst_mid_bytes", tx_q.size(), 5);
      #1 rst_n = 1'b0;
      #1 check_zero_outputs("rst_mid");
      tx_q.delete();
      repeat (3) @(posedge clk);
      #1 rst_n = 1'b1;
      repeat (3) @(negedge clk);
      check_eq("rst_mid_no_tx", tx_q.size(), 0);
      do_run(1'b1, 4, 1'b0, 1'b0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/utpu_host_ctrl.md
Name: utpu_host_ctrl

Overview:
- Byte-level command sequencer between the UART byte interfaces and the uTPU compute core.
- Decodes host opcodes, streams operand bytes into the weight/activation buffers, launches the core, and streams results back out over TX.
- Also accepts a board-level `start` pulse as an alternate RUN trigger.
- Sits in `top` between `uart_rx`/`uart_tx` and the systolic array plus its buffers.

Parameters:
- `N`, 4, systolic array dimension; each operand matrix is N*N bytes.
- `ACC_W`, 32, result word width in bits; must be a multiple of 8.
- `TIMEOUT`, 100000, max clk cycles between operand bytes before a load is aborted.
- `ADDR_W`, $clog2(N*N), buffer/result address width.

Ports:
- `clk` in 1: system clock.
- `rst_n` in 1: asynchronous active-low reset.
- `start` in 1: one-cycle RUN request; honoured only in IDLE.
- `rx_valid` in 1: one-cycle strobe, received byte available.
- `rx_data` in 8: received byte.
- `tx_valid` out 1: byte offered to the transmitter.
- `tx_ready` in 1: transmitter accepts the byte when `tx_valid && tx_ready`.
- `tx_data` out 8: byte to transmit.
- `buf_we` out 1: operand buffer write strobe.
- `buf_sel` out 1: 0 = weight buffer, 1 = activation buffer.
- `buf_addr` out ADDR_W: operand write address.
- `buf_wdata` out 8: operand byte.
- `core_start` out 1: one-cycle launch pulse to the core.
- `core_done` in 1: one-cycle completion pulse from the core.
- `res_addr` out ADDR_W: result RAM read address.
- `res_rdata` in ACC_W: result word, valid 1 cycle after `res_addr`.
- `busy` out 1: high in any state other than IDLE.
- `err` out 1: one-cycle pulse on bad opcode or timeout.

Behaviour:
- Reset (async, `rst_n` = 0):
  - state = IDLE.
  - All outputs 0.
  - Counters cleared.
  - A reset mid-operation abandons the transfer; no byte is sent.
- Opcodes, decoded from the rx byte received in IDLE:
  - 0x01 LOAD_W, 0x02 LOAD_X, 0x03 RUN, 0x04 READ.
  - Any other opcode: queue response 0xEE, pulse `err`, go to SEND.
- LOAD state:
  - Each `rx_valid` drives `buf_we` = 1 in the same cycle, registered.
  - Write fields: `buf_addr` = idx, `buf_wdata` = `rx_data`, `buf_sel` per opcode.
  - idx increments 0..N*N-1.
  - After write N*N-1: queue ACK 0xA5, go to SEND.
  - The gap counter resets on each byte. If it reaches TIMEOUT: queue 0xEE, pulse `err`, go to SEND. Buffer contents written so far are kept.
- RUN (opcode 0x03, or `start` in IDLE):
  - RUN_START asserts `core_start` for exactly 1 cycle.
  - RUN_WAIT waits for `core_done`; there is no timeout.
  - On done: queue 0xD0, go to SEND.
  - If `start` and `rx_valid` arrive in the same IDLE cycle, `start` wins and the rx byte is dropped.
- READ, for k = 0..N*N-1:
  - RD_ADDR drives `res_addr` = k.
  - RD_WAIT (1 cycle) latches `res_rdata`.
  - RD_SEND emits ACC_W/8 bytes, MSB first, each on a `tx_valid`/`tx_ready` handshake.
  - After the last byte of word N*N-1, return to IDLE. READ sends no trailing ACK.
- SEND:
  - `tx_valid` = 1 with the queued byte until `tx_ready` is seen.
  - Then `tx_valid` drops the next cycle and the state returns to IDLE.
  - `tx_data` is stable while `tx_valid` is high.
- `rx_valid` outside IDLE and LOAD is ignored and dropped.
- `busy` is combinational from state (`state != IDLE`).
- Latencies:
  - Opcode byte → first buffer write possible the next cycle.
  - `core_done` → `tx_valid` in 2 cycles.

Decomposition:
- Package `utpu_pkg` holds:
  - the opcode constants (OP_LOAD_W, OP_LOAD_X, OP_RUN, OP_READ);
  - the response constants (RSP_ACK = 0xA5, RSP_DONE = 0xD0, RSP_ERR = 0xEE);
  - the `ctrl_state_e` enum.
- One natural sub-module, `utpu_byte_serializer`: loads an ACC_W word and emits its bytes MSB first over the valid/ready handshake. It is reused for single-byte responses with width 8.

Test Plan (N=2, ACC_W=32, TIMEOUT=50):
- LOAD_W: rx 0x01,0x11,0x22,0x33,0x44 → `buf_we` ×4, `buf_sel` = 0, addr 0..3 carrying 0x11..0x44; tx 0xA5.
- RUN: rx 0x03 → one `core_start` pulse; `busy` = 1; drive `core_done` 20 cycles later → tx 0xD0 two cycles after; `busy` = 0 after the handshake.
- READ: `res_rdata` = {0x01020304, 0x05060708, 0x0A0B0C0D, 0xFFFFFFFF} at addr 0..3; rx 0x04 → tx 16 bytes 01 02 03 04 05 … FF, in order. Repeat with `tx_ready` toggling randomly; the order must be unchanged.
- Bad opcode 0x7F → `err` pulses 1 cycle; tx 0xEE; IDLE afterwards.
- Timeout: rx 0x02,0xAA then silence for 50 cycles → `err`; tx 0xEE; one write only (addr 0, `buf_sel` = 1).
- Reset mid-READ (`rst_n` low after 5 tx bytes) → all outputs 0 immediately; after release, a fresh RUN via `start` pulse gives `core_start`.
